// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit_if
//  Purpose  : Request, memory and register-file write bundle of the load unit.
//             The slave view belongs to the load unit and the master view to
//             the core/memory side that surrounds it.
//  Revision : 1.0  initial release
// ============================================================================
interface load_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [WIDTH-1:0]      req_addr;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_rd;
    logic [WIDTH-1:0]      mem_addr;
    logic                  mem_enable;
    logic                  mem_data_ready;
    logic [WIDTH-1:0]      mem_rdata;
    logic [ADDR_WIDTH-1:0] ra3;
    logic [WIDTH-1:0]      wd3;
    logic                  we3;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pending_rd;
    logic                  fault;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd, mem_data_ready, mem_rdata,
        output req_ready, mem_addr, mem_enable, ra3, wd3, we3, pending, pending_rd, fault
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_rd, mem_data_ready, mem_rdata,
        input  req_ready, mem_addr, mem_enable, ra3, wd3, we3, pending, pending_rd, fault
    );
endinterface
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Single-outstanding load stage. Accepts a load request, issues a
//             word-aligned memory read, extracts and extends the addressed
//             byte/halfword/word and writes it back as a one-cycle pulse.
//  Revision : 1.0  initial release
// ============================================================================
module load_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 255
) (
    input  wire logic  clk,
    input  wire logic  rst,
    load_unit_if.slave bus
);

    localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_mem_enable;
    logic                  r_we3;
    logic                  r_fault;
    logic                  r_pending;
    logic [WIDTH-1:0]      r_mem_addr;
    logic [WIDTH-1:0]      r_wd3;
    logic [ADDR_WIDTH-1:0] r_ra3;
    logic [ADDR_WIDTH-1:0] r_pending_rd;
    logic [2:0]            r_funct3;
    logic [1:0]            r_lane;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_legal;
    logic                  w_timeout;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WIDTH-1:0]      w_load_data;

    // Classify the incoming request: unknown funct3 or misaligned half/word is illegal
    always_comb begin
        w_legal = 1'b0;
        case (bus.req_funct3)
            3'd0, 3'd4: w_legal = 1'b1;
            3'd1, 3'd5: w_legal = ~bus.req_addr[0];
            3'd2:       w_legal = (bus.req_addr[1:0] == 2'b00);
            default:    w_legal = 1'b0;
        endcase
    end

    // Wait counter; a zero TIMEOUT never expires
    always_comb begin
        w_cnt_next = r_cnt + c_cnt_w'(1);
        w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_cnt_w'(TIMEOUT));
    end

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'd4:    w_load_data = {{(WIDTH-8){1'b0}}, w_byte};
            3'd1:    w_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
            3'd5:    w_load_data = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Control FSM with all outputs registered; write/fault pulses default low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_enable <= 1'b0;
            r_we3        <= 1'b0;
            r_fault      <= 1'b0;
            r_pending    <= 1'b0;
            r_mem_addr   <= '0;
            r_wd3        <= '0;
            r_ra3        <= '0;
            r_pending_rd <= '0;
            r_funct3     <= '0;
            r_lane       <= '0;
            r_cnt        <= '0;
        end else begin
            r_we3   <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pending <= 1'b0;
                    if (bus.req_valid && r_req_ready) begin
                        r_funct3     <= bus.req_funct3;
                        r_lane       <= bus.req_addr[1:0];
                        r_pending_rd <= bus.req_rd;
                        if (w_legal) begin
                            r_state      <= S_WAIT;
                            r_req_ready  <= 1'b0;
                            r_mem_enable <= 1'b1;
                            r_mem_addr   <= {bus.req_addr[WIDTH-1:2], 2'b00};
                            r_cnt        <= '0;
                            r_pending    <= 1'b1;
                        end else begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_data_ready) begin
                        // Data wins over a timeout that expires in the same cycle
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_mem_enable <= 1'b0;
                        r_we3        <= 1'b1;
                        r_wd3        <= w_load_data;
                        r_ra3        <= r_pending_rd;
                        r_pending    <= 1'b1;
                    end else if (w_timeout) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_mem_enable <= 1'b0;
                        r_fault      <= 1'b1;
                        r_pending    <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_enable = r_mem_enable;
    assign bus.ra3        = r_ra3;
    assign bus.wd3        = r_wd3;
    assign bus.we3        = r_we3;
    assign bus.pending    = r_pending;
    assign bus.pending_rd = r_pending_rd;
    assign bus.fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Self-checking bench for load_unit. Two instances: TIMEOUT=3 and
//             TIMEOUT=0. Expected writebacks/faults are queued at issue time
//             and popped by per-instance monitors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_wb_cyc = 0;
    int   first_wb_cyc = 0;
    int   exp_fault_a = 0;
    int   exp_fault_b = 0;
    logic [36:0] exp_q_a[$];
    logic [36:0] exp_q_b[$];

    load_unit_if #(.ADDR_WIDTH(5), .WIDTH(32)) bus_a ();
    load_unit_if #(.ADDR_WIDTH(5), .WIDTH(32)) bus_b ();

    load_unit #(.ADDR_WIDTH(5), .WIDTH(32), .TIMEOUT(3)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    load_unit #(.ADDR_WIDTH(5), .WIDTH(32), .TIMEOUT(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for instance A: every writeback/fault must have been predicted
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (bus_a.we3 === 1'b1) begin
                check("we3_expected_a", exp_q_a.size() > 0, 1);
                if (exp_q_a.size() > 0) begin
                    check("writeback_a", {bus_a.ra3, bus_a.wd3}, exp_q_a[0]);
                    void'(exp_q_a.pop_front());
                end
            end
            if (bus_a.fault === 1'b1) begin
                check("fault_expected_a", exp_fault_a > 0, 1);
                if (exp_fault_a > 0) exp_fault_a = exp_fault_a - 1;
            end
        end
    end

    // Monitor for instance B
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (bus_b.we3 === 1'b1) begin
                check("we3_expected_b", exp_q_b.size() > 0, 1);
                if (exp_q_b.size() > 0) begin
                    check("writeback_b", {bus_b.ra3, bus_b.wd3}, exp_q_b[0]);
                    void'(exp_q_b.pop_front());
                end
            end
            if (bus_b.fault === 1'b1) begin
                check("fault_expected_b", exp_fault_b > 0, 1);
                if (exp_fault_b > 0) exp_fault_b = exp_fault_b - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Legal load on instance A; called 1ns after an edge with A in IDLE
    task automatic load_a(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits, input logic [31:0] exp);
        check("req_ready_before_accept", bus_a.req_ready, 1);
        exp_q_a.push_back({rd, exp});
        bus_a.req_valid  = 1'b1;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = addr;
        bus_a.req_rd     = rd;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        check("mem_enable_after_accept", bus_a.mem_enable, 1);
        check("req_ready_in_wait", bus_a.req_ready, 0);
        check("mem_addr", bus_a.mem_addr, {addr[31:2], 2'b00});
        check("pending_rd", bus_a.pending_rd, rd);
        check("pending_in_wait", bus_a.pending, 1);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            check("mem_addr_stable", bus_a.mem_addr, {addr[31:2], 2'b00});
            check("mem_enable_held", bus_a.mem_enable, 1);
        end
        bus_a.mem_data_ready = 1'b1;
        bus_a.mem_rdata      = rdata;
        @(posedge clk); #1;
        bus_a.mem_data_ready = 1'b0;
        bus_a.mem_rdata      = 32'h0;
        check("we3_pulse", bus_a.we3, 1);
        check("mem_enable_drop", bus_a.mem_enable, 0);
        check("pending_in_we3", bus_a.pending, 1);
        check("req_ready_in_we3", bus_a.req_ready, 1);
        last_wb_cyc = cyc;
    endtask

    // Illegal request on instance A: fault next cycle, no memory access
    task automatic illegal_a(input logic [2:0] f3, input logic [31:0] addr);
        exp_fault_a = exp_fault_a + 1;
        bus_a.req_valid  = 1'b1;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = addr;
        bus_a.req_rd     = 5'd4;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        check("illegal_fault", bus_a.fault, 1);
        check("illegal_req_ready", bus_a.req_ready, 1);
        check("illegal_no_mem_enable", bus_a.mem_enable, 0);
        check("illegal_no_we3", bus_a.we3, 0);
        check("illegal_no_pending", bus_a.pending, 0);
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_funct3 = '0; bus_a.req_rd = '0;
        bus_a.mem_data_ready = 1'b0; bus_a.mem_rdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_funct3 = '0; bus_b.req_rd = '0;
        bus_b.mem_data_ready = 1'b0; bus_b.mem_rdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus_a.req_ready, 1);
        check("rst_mem_enable", bus_a.mem_enable, 0);
        check("rst_we3", bus_a.we3, 0);
        check("rst_fault", bus_a.fault, 0);
        check("rst_pending", bus_a.pending, 0);
        check("rst_outputs", {bus_a.ra3, bus_a.wd3, bus_a.mem_addr, bus_a.pending_rd}, 0);
        check("rst_req_ready_b", bus_b.req_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word load with zero-wait memory
        load_a(3'd2, 32'h10, 5'd5, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("pending_clears", bus_a.pending, 0);
        check("we3_single_pulse", bus_a.we3, 0);

        // Extraction and extension, issued back to back
        load_a(3'd0, 32'h13, 5'd10, 32'h80FF1234, 0, 32'hFFFFFF80);
        load_a(3'd4, 32'h13, 5'd11, 32'h80FF1234, 0, 32'h00000080);
        load_a(3'd1, 32'h12, 5'd12, 32'h80FF1234, 0, 32'hFFFF80FF);
        load_a(3'd5, 32'h10, 5'd13, 32'h80FF1234, 0, 32'h00001234);
        load_a(3'd0, 32'h11, 5'd14, 32'h80FF1234, 1, 32'h00000012);
        load_a(3'd1, 32'h10, 5'd15, 32'h80FF9234, 0, 32'hFFFF9234);
        load_a(3'd2, 32'h14, 5'd0,  32'h12345678, 0, 32'h12345678);
        @(posedge clk); #1;

        // Illegal requests
        illegal_a(3'd2, 32'h02);
        illegal_a(3'd3, 32'h10);
        illegal_a(3'd1, 32'h11);
        illegal_a(3'd5, 32'h13);
        illegal_a(3'd7, 32'h00);
        @(posedge clk); #1;
        check("illegal_fault_single", bus_a.fault, 0);
        check("illegal_still_no_mem", bus_a.mem_enable, 0);

        // Timeout with TIMEOUT=3: fault in the 4th cycle after WAIT entry
        bus_a.req_valid = 1'b1; bus_a.req_funct3 = 3'd2; bus_a.req_addr = 32'h20; bus_a.req_rd = 5'd7;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        exp_fault_a = exp_fault_a + 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("timeout_not_early", bus_a.fault, 0);
        check("timeout_wait_held", bus_a.mem_enable, 1);
        @(posedge clk); #1;
        check("timeout_fault", bus_a.fault, 1);
        check("timeout_idle", bus_a.req_ready, 1);
        check("timeout_mem_drop", bus_a.mem_enable, 0);
        check("timeout_pending", bus_a.pending, 0);
        bus_a.mem_data_ready = 1'b1; bus_a.mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_a.mem_data_ready = 1'b0;
        check("late_ready_no_we3", bus_a.we3, 0);
        check("timeout_fault_single", bus_a.fault, 0);

        // Data arriving as the counter reaches TIMEOUT wins
        load_a(3'd2, 32'h24, 5'd8, 32'hA5A5A5A5, 2, 32'hA5A5A5A5);
        check("data_wins_no_fault", bus_a.fault, 0);
        @(posedge clk); #1;
        check("data_wins_no_late_fault", bus_a.fault, 0);

        // Back-to-back words: second accepted in the first one's we3 cycle
        load_a(3'd2, 32'h40, 5'd1, 32'h11111111, 0, 32'h11111111);
        first_wb_cyc = last_wb_cyc;
        load_a(3'd2, 32'h44, 5'd2, 32'h22222222, 0, 32'h22222222);
        check("b2b_we3_spacing", last_wb_cyc - first_wb_cyc, 2);
        @(posedge clk); #1;

        // TIMEOUT=0: five cycles without ready, then normal writeback
        exp_q_b.push_back({5'd3, 32'hCAFEF00D});
        bus_b.req_valid = 1'b1; bus_b.req_funct3 = 3'd2; bus_b.req_addr = 32'h08; bus_b.req_rd = 5'd3;
        @(posedge clk); #1;
        bus_b.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("no_timeout_wait", bus_b.mem_enable, 1);
            check("no_timeout_fault", bus_b.fault, 0);
            @(posedge clk); #1;
        end
        bus_b.mem_data_ready = 1'b1; bus_b.mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_b.mem_data_ready = 1'b0;
        check("no_timeout_we3", bus_b.we3, 1);
        check("no_timeout_ra3", bus_b.ra3, 3);
        @(posedge clk); #1;

        // Reset during the 2nd WAIT cycle, then a late ready
        bus_a.req_valid = 1'b1; bus_a.req_funct3 = 3'd2; bus_a.req_addr = 32'h30; bus_a.req_rd = 5'd9;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.mem_data_ready = 1'b1; bus_a.mem_rdata = 32'h99999999;
        check("midrst_req_ready", bus_a.req_ready, 1);
        check("midrst_mem_enable", bus_a.mem_enable, 0);
        check("midrst_flags", {bus_a.we3, bus_a.fault, bus_a.pending}, 0);
        check("midrst_outputs", {bus_a.ra3, bus_a.wd3, bus_a.mem_addr, bus_a.pending_rd}, 0);
        @(posedge clk); #1;
        bus_a.mem_data_ready = 1'b0;
        check("midrst_no_we3", bus_a.we3, 0);
        check("midrst_no_fault", bus_a.fault, 0);
        check("midrst_stays_idle", bus_a.mem_enable, 0);
        @(posedge clk); #1;

        check("writebacks_outstanding_a", exp_q_a.size(), 0);
        check("faults_outstanding_a", exp_fault_a, 0);
        check("writebacks_outstanding_b", exp_q_b.size(), 0);
        check("faults_outstanding_b", exp_fault_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
